pockets_render: RTL and testbench
=================================

POCKETS_RENDER -- requirements
Module: pockets_render

Interface
REQ-001 Parameters SHALL be: TOP_OFFSET 0, table top edge row; DOWN_OFFSET 479, bottom edge row; LEFT_OFFSET 0, left edge column; RIGHT_OFFSET 639, right edge column.
REQ-002 Parameters SHALL further be: HOLE_SIZE 32, pocket square side in pixels, power of two, 8..64; FLASH_FRAMES 30, flash duration in frames; HOLE_COLOR 8'h00, pocket colour; FLASH_COLOR 8'hFC, highlight colour.
REQ-003 Ports, in order:
- clk in 1, system clock.
- resetN in 1, synchronous active-low reset.
- pixelX in 11, current scan column.
- pixelY in 11, current scan row.
- startOfFrame in 1, one-cycle pulse per frame.
- pocketHit in 1, one-cycle pulse: a ball was pocketed.
- pocketHitNum in 3, pocket id for pocketHit, 1..6.
- holeNumber out 3, pocket under pixel, 0 = none.
- drawingRequestHoles out 1, opaque pocket pixel.
- RGBoutHoles out 8, pixel colour, 8'hFF = transparent.
- sinkCount out 4, pocketed balls since reset, saturating.

Function
REQ-004 Pocket ids SHALL be 1 top-left, 2 top-middle, 3 top-right, 4 bottom-right, 5 bottom-middle, 6 bottom-left.
REQ-005 Pocket centres SHALL be: columns LEFT_OFFSET, (LEFT_OFFSET+RIGHT_OFFSET)/2, RIGHT_OFFSET; rows TOP_OFFSET, DOWN_OFFSET.
REQ-006 Each box SHALL span centre-HOLE_SIZE/2 to centre+HOLE_SIZE/2-1 on both axes; coordinates SHALL be evaluated as 12-bit signed, so negative box origins never wrap to large unsigned values.
REQ-007 Local offsets dx, dy SHALL be pixel minus box origin, range 0..HOLE_SIZE-1; a pixel is inside the disc when (2dx-(HOLE_SIZE-1))^2 + (2dy-(HOLE_SIZE-1))^2 <= HOLE_SIZE^2, using widths with no overflow.
REQ-008 If boxes overlap, the lowest pocket id SHALL win.
REQ-009 All outputs except sinkCount SHALL be registered with exactly one clk of latency from pixelX/pixelY; holeNumber, drawingRequestHoles and RGBoutHoles SHALL describe the same pixel in the same cycle.
REQ-010 Inside a box but outside the disc: holeNumber = id, drawingRequestHoles = 0, RGBoutHoles = 8'hFF. Outside all boxes: 0, 0, 8'hFF.
REQ-011 Inside the disc: drawingRequestHoles = 1; RGBoutHoles = HOLE_COLOR when the pocket is IDLE, and per REQ-014 when it is FLASH.
REQ-012 Each pocket SHALL have a two-state FSM, IDLE and FLASH, plus a frame counter of width clog2(FLASH_FRAMES+1).
REQ-013 FSM transitions:
- pocketHit with a matching pocketHitNum SHALL enter FLASH and load counter = FLASH_FRAMES; a hit during FLASH restarts.
- In FLASH, each startOfFrame SHALL decrement the counter; when it reaches 0, return to IDLE.
- When a hit and startOfFrame coincide on a pocket, the hit wins: reload, no decrement.
REQ-014 In FLASH, disc pixels SHALL be FLASH_COLOR when counter bit 2 = 1 and HOLE_COLOR otherwise.
REQ-015 pocketHitNum values 0 and 7 SHALL be ignored: no FSM change and no count.
REQ-016 sinkCount SHALL increment by 1 on each valid pocketHit and saturate at 15; it is registered, and the count is visible the cycle after the hit.

Reset
REQ-017 When resetN = 0 at a clk edge: holeNumber 0, drawingRequestHoles 0, RGBoutHoles 8'hFF, sinkCount 0, all FSMs IDLE, counters 0; this applies mid-flash and overrides a simultaneous pocketHit.

Structure
REQ-018 A shared package holes_pkg SHALL hold TRANSPARENT_ENCODING (8'hFF), the pocket-id constants 1..6, and the IDLE/FLASH state enum.
REQ-019 Sub-module pocket_flash SHALL implement one FSM and its counter; pockets_render SHALL instantiate six copies via generate.

Verification
REQ-020 After reset, pixel (320,0) with defaults -> one cycle later holeNumber 2, drawingRequestHoles 1, RGBoutHoles 8'h00.
REQ-021 Pixel (0,0) -> holeNumber 1, request 1; pixel (15,15) -> holeNumber 1, request 0, RGB 8'hFF (corner outside disc); pixel (100,100) -> 0, 0, 8'hFF.
REQ-022 Scenario: pocketHit with pocketHitNum 4, then 30 startOfFrame pulses. Required: disc pixel (639,479) shows FLASH_COLOR while counter bit 2 = 1; 8'h00 after the 30th pulse; sinkCount 1.
REQ-023 pocketHitNum 0 and then 7 -> no state change and sinkCount stays 0; 20 valid hits -> sinkCount 15.
REQ-024 A hit coincident with startOfFrame reloads the counter to 30; resetN low mid-flash -> IDLE and all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/holes_pkg.sv
// Shared definitions for the pool-table pocket renderer.
//   TRANSPARENT_ENCODING : colour value meaning "nothing drawn here".
//   POCKET_*             : pocket ids, 0 = no pocket.
//   flash_state_t        : per-pocket highlight state.
package holes_pkg;

  localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

  localparam logic [2:0] POCKET_NONE         = 3'd0;
  localparam logic [2:0] POCKET_TOP_LEFT     = 3'd1;
  localparam logic [2:0] POCKET_TOP_MID      = 3'd2;
  localparam logic [2:0] POCKET_TOP_RIGHT    = 3'd3;
  localparam logic [2:0] POCKET_BOTTOM_RIGHT = 3'd4;
  localparam logic [2:0] POCKET_BOTTOM_MID   = 3'd5;
  localparam logic [2:0] POCKET_BOTTOM_LEFT  = 3'd6;

  localparam int unsigned NUM_POCKETS = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } flash_state_t;

endpackage

// File: rtl/pocket_flash.sv
// Highlight state machine for a single pocket.
//   clk, resetN  : clock, synchronous active-low reset
//   hit_i        : this pocket was just hit (already qualified by id)
//   sof_i        : start-of-frame pulse
//   flash_bit_o  : 1 when the pocket is flashing and the frame counter bit 2 is set
module pocket_flash
  import holes_pkg::*;
#(
  parameter int FLASH_FRAMES = 30
) (
  input  logic clk,
  input  logic resetN,
  input  logic hit_i,
  input  logic sof_i,
  output logic flash_bit_o
);

  localparam int CNT_W = $clog2(FLASH_FRAMES + 1);

  flash_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Zero-extended copy so bit 2 exists even for very short flash lengths.
  logic [CNT_W+2:0] cnt_ext;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A hit takes priority over a coincident frame pulse: reload, no decrement.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (hit_i) begin
      state_d = FLASH;
      cnt_d   = CNT_W'(FLASH_FRAMES);
    end else if (state_q == FLASH && sof_i) begin
      if (cnt_q <= CNT_W'(1)) begin
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  assign cnt_ext     = {3'b000, cnt_q};
  assign flash_bit_o = (state_q == FLASH) && cnt_ext[2];

endmodule

// File: rtl/pockets_render.sv
// Draws the six table pockets as discs and flashes a pocket after a ball sinks.
//   clk, resetN         : clock, synchronous active-low reset
//   pixelX, pixelY      : current scan position
//   startOfFrame        : one pulse per frame, paces the flash
//   pocketHit/HitNum    : a ball went into pocket 1..6 (0 and 7 ignored)
//   holeNumber          : pocket box under the pixel, 0 = none   (1 clk latency)
//   drawingRequestHoles : pixel is inside a pocket disc          (1 clk latency)
//   RGBoutHoles         : pixel colour, TRANSPARENT_ENCODING off-disc (1 clk latency)
//   sinkCount           : balls pocketed since reset, saturates at 15
module pockets_render
  import holes_pkg::*;
#(
  parameter int         TOP_OFFSET   = 0,
  parameter int         DOWN_OFFSET  = 479,
  parameter int         LEFT_OFFSET  = 0,
  parameter int         RIGHT_OFFSET = 639,
  parameter int         HOLE_SIZE    = 32,
  parameter int         FLASH_FRAMES = 30,
  parameter logic [7:0] HOLE_COLOR   = 8'h00,
  parameter logic [7:0] FLASH_COLOR  = 8'hFC
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        pocketHit,
  input  logic [2:0]  pocketHitNum,
  output logic [2:0]  holeNumber,
  output logic        drawingRequestHoles,
  output logic [7:0]  RGBoutHoles,
  output logic [3:0]  sinkCount
);

  localparam int HALF  = HOLE_SIZE / 2;
  localparam int MID_X = (LEFT_OFFSET + RIGHT_OFFSET) / 2;

  function automatic int centre_x(int unsigned idx);
    case (idx)
      0, 5:    return LEFT_OFFSET;
      1, 4:    return MID_X;
      default: return RIGHT_OFFSET;
    endcase
  endfunction

  function automatic int centre_y(int unsigned idx);
    return (idx < 3) ? TOP_OFFSET : DOWN_OFFSET;
  endfunction

  logic [NUM_POCKETS-1:0] hit_vec;
  logic [NUM_POCKETS-1:0] flash_bit;
  logic                   valid_hit;

  assign valid_hit = pocketHit && (pocketHitNum >= POCKET_TOP_LEFT)
                               && (pocketHitNum <= POCKET_BOTTOM_LEFT);

  for (genvar g = 0; g < NUM_POCKETS; g++) begin : g_pocket
    assign hit_vec[g] = pocketHit && (pocketHitNum == 3'(g + 1));
    pocket_flash #(.FLASH_FRAMES(FLASH_FRAMES)) u_flash (
      .clk         (clk),
      .resetN      (resetN),
      .hit_i       (hit_vec[g]),
      .sof_i       (startOfFrame),
      .flash_bit_o (flash_bit[g])
    );
  end

  logic [2:0] hole_q, hole_d;
  logic       req_q, req_d;
  logic [7:0] rgb_q, rgb_d;
  logic [3:0] sink_q, sink_d;

  // Geometry is done in 32-bit signed arithmetic, so box origins left of or
  // above the screen stay negative and the disc test cannot overflow.
  always_comb begin
    int   px, py, dx, dy, tx, ty;
    logic found;
    hole_d = POCKET_NONE;
    req_d  = 1'b0;
    rgb_d  = TRANSPARENT_ENCODING;
    found  = 1'b0;
    px     = int'(pixelX);
    py     = int'(pixelY);
    dx     = 0;
    dy     = 0;
    tx     = 0;
    ty     = 0;
    // Ascending scan with a found flag: the lowest pocket id wins overlaps.
    for (int unsigned i = 0; i < NUM_POCKETS; i++) begin
      dx = px - (centre_x(i) - HALF);
      dy = py - (centre_y(i) - HALF);
      tx = 2 * dx - (HOLE_SIZE - 1);
      ty = 2 * dy - (HOLE_SIZE - 1);
      if (!found && dx >= 0 && dx < HOLE_SIZE && dy >= 0 && dy < HOLE_SIZE) begin
        found  = 1'b1;
        hole_d = 3'(i + 1);
        if (tx * tx + ty * ty <= HOLE_SIZE * HOLE_SIZE) begin
          req_d = 1'b1;
          rgb_d = flash_bit[i] ? FLASH_COLOR : HOLE_COLOR;
        end
      end
    end
  end

  always_comb begin
    sink_d = sink_q;
    if (valid_hit && sink_q != 4'hF) begin
      sink_d = sink_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      hole_q <= POCKET_NONE;
      req_q  <= 1'b0;
      rgb_q  <= TRANSPARENT_ENCODING;
      sink_q <= '0;
    end else begin
      hole_q <= hole_d;
      req_q  <= req_d;
      rgb_q  <= rgb_d;
      sink_q <= sink_d;
    end
  end

  assign holeNumber          = hole_q;
  assign drawingRequestHoles = req_q;
  assign RGBoutHoles         = rgb_q;
  assign sinkCount           = sink_q;

endmodule

// File: tb/tb_pockets_render.sv
module tb_pockets_render;

  localparam int         H     = 32;
  localparam int         NF    = 30;
  localparam int         TOP   = 0;
  localparam int         DOWN  = 479;
  localparam int         LEFT  = 0;
  localparam int         RIGHT = 639;
  localparam logic [7:0] HC    = 8'h00;
  localparam logic [7:0] FC    = 8'hFC;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [10:0] pixelX = '0;
  logic [10:0] pixelY = '0;
  logic        startOfFrame = 1'b0;
  logic        pocketHit = 1'b0;
  logic [2:0]  pocketHitNum = '0;
  logic [2:0]  holeNumber;
  logic        drawingRequestHoles;
  logic [7:0]  RGBoutHoles;
  logic [3:0]  sinkCount;

  always #5 clk = ~clk;

  pockets_render #(
    .TOP_OFFSET  (TOP),
    .DOWN_OFFSET (DOWN),
    .LEFT_OFFSET (LEFT),
    .RIGHT_OFFSET(RIGHT),
    .HOLE_SIZE   (H),
    .FLASH_FRAMES(NF),
    .HOLE_COLOR  (HC),
    .FLASH_COLOR (FC)
  ) dut (
    .clk                (clk),
    .resetN             (resetN),
    .pixelX             (pixelX),
    .pixelY             (pixelY),
    .startOfFrame       (startOfFrame),
    .pocketHit          (pocketHit),
    .pocketHitNum       (pocketHitNum),
    .holeNumber         (holeNumber),
    .drawingRequestHoles(drawingRequestHoles),
    .RGBoutHoles        (RGBoutHoles),
    .sinkCount          (sinkCount)
  );

  typedef struct {
    int         x;
    int         y;
    logic [2:0] hole;
    logic       req;
    logic [7:0] rgb;
    logic [3:0] sink;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference state: frames of flash left per pocket (0 = not flashing) and ball count.
  int remaining[6];
  int sink_m = 0;
  int cx[6] = '{LEFT, (LEFT + RIGHT) / 2, RIGHT, RIGHT, (LEFT + RIGHT) / 2, LEFT};
  int cy[6] = '{TOP, TOP, TOP, DOWN, DOWN, DOWN};

  // Pixel (x,y) relative to centre (cx,cy): in box when -H/2 <= x-cx < H/2;
  // pixel-centre distance in half-pixels is 2(x-cx)+1.
  function automatic exp_t model_pixel(int x, int y);
    exp_t e;
    e.x = x; e.y = y;
    e.hole = 3'd0; e.req = 1'b0; e.rgb = 8'hFF; e.sink = 4'd0;
    for (int k = 5; k >= 0; k--) begin
      int ox = x - cx[k];
      int oy = y - cy[k];
      if (ox >= -H / 2 && ox < H / 2 && oy >= -H / 2 && oy < H / 2) begin
        e.hole = 3'(k + 1);
        e.req  = 1'b0;
        e.rgb  = 8'hFF;
        if ((2 * ox + 1) ** 2 + (2 * oy + 1) ** 2 <= H * H) begin
          e.req = 1'b1;
          e.rgb = (remaining[k] > 0 && (remaining[k] % 8) >= 4) ? FC : HC;
        end
      end
    end
    return e;
  endfunction

  task automatic step(input int x, input int y, input logic sof, input logic hit,
                      input int num, input logic rstn);
    exp_t e;
    @(negedge clk);
    pixelX       = 11'(x);
    pixelY       = 11'(y);
    startOfFrame = sof;
    pocketHit    = hit;
    pocketHitNum = 3'(num);
    resetN       = rstn;
    if (!rstn) begin
      e.x = x; e.y = y; e.hole = 3'd0; e.req = 1'b0; e.rgb = 8'hFF;
      for (int k = 0; k < 6; k++) remaining[k] = 0;
      sink_m = 0;
    end else begin
      e = model_pixel(x, y);
      for (int k = 0; k < 6; k++) begin
        if (hit && num == k + 1) remaining[k] = NF;
        else if (sof && remaining[k] > 0) remaining[k]--;
      end
      if (hit && num >= 1 && num <= 6 && sink_m < 15) sink_m++;
    end
    e.sink = 4'(sink_m);
    exp_q.push_back(e);
  endtask

  // Monitor: every output cycle with a pending expectation is compared.
  initial begin
    exp_t e;
    logic bad;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        bad = 1'b0;
        vectors++;
        if (holeNumber !== e.hole) begin
          $display("FAIL holeNumber @(%0d,%0d): got %0d expected %0d", e.x, e.y, holeNumber, e.hole);
          bad = 1'b1;
        end
        if (drawingRequestHoles !== e.req) begin
          $display("FAIL drawingRequest @(%0d,%0d): got %0b expected %0b", e.x, e.y, drawingRequestHoles, e.req);
          bad = 1'b1;
        end
        if (RGBoutHoles !== e.rgb) begin
          $display("FAIL RGB @(%0d,%0d): got %02h expected %02h", e.x, e.y, RGBoutHoles, e.rgb);
          bad = 1'b1;
        end
        if (sinkCount !== e.sink) begin
          $display("FAIL sinkCount: got %0d expected %0d", sinkCount, e.sink);
          bad = 1'b1;
        end
        if (bad) miscompares++;
      end
    end
  end

  function automatic int near_coord(int c);
    int v = c + $urandom_range(0, 48) - 24;
    if (v < 0) v = $urandom_range(0, 8);
    return v;
  endfunction

  initial begin
    int x, y, k;
    // Reset
    for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b0, 0, 1'b0);
    // Fixed pixels around pocket geometry
    step(320, 0, 1'b0, 1'b0, 0, 1'b1);
    step(0, 0, 1'b0, 1'b0, 0, 1'b1);
    step(15, 15, 1'b0, 1'b0, 0, 1'b1);
    step(100, 100, 1'b0, 1'b0, 0, 1'b1);
    step(639, 479, 1'b0, 1'b0, 0, 1'b1);
    step(303, 16, 1'b0, 1'b0, 0, 1'b1);
    step(2047, 2047, 1'b0, 1'b0, 0, 1'b1);
    // Invalid pocket ids
    step(0, 0, 1'b0, 1'b1, 0, 1'b1);
    step(639, 479, 1'b1, 1'b1, 7, 1'b1);
    step(639, 479, 1'b0, 1'b0, 0, 1'b1);
    // Flash pocket 4 over 30 frames
    step(639, 479, 1'b0, 1'b1, 4, 1'b1);
    for (int f = 0; f < NF; f++) begin
      step(639, 479, 1'b1, 1'b0, 0, 1'b1);
      step(639, 479, 1'b0, 1'b0, 0, 1'b1);
      step(628, 470, 1'b0, 1'b0, 0, 1'b1);
    end
    step(639, 479, 1'b1, 1'b0, 0, 1'b1);
    // Hit coincident with frame pulse reloads
    step(639, 479, 1'b0, 1'b1, 4, 1'b1);
    for (int f = 0; f < 5; f++) step(639, 479, 1'b1, 1'b0, 0, 1'b1);
    step(639, 479, 1'b1, 1'b1, 4, 1'b1);
    for (int f = 0; f < 8; f++) step(639, 479, 1'b1, 1'b0, 0, 1'b1);
    // Reset mid-flash, overriding a simultaneous hit
    step(319, 0, 1'b0, 1'b1, 2, 1'b1);
    for (int f = 0; f < 3; f++) step(319, 0, 1'b1, 1'b0, 0, 1'b1);
    step(319, 0, 1'b0, 1'b1, 2, 1'b0);
    for (int f = 0; f < 6; f++) step(319, 0, 1'b1, 1'b0, 0, 1'b1);
    // Saturation of sinkCount
    for (int i = 0; i < 20; i++) step(0, 479, 1'b0, 1'b1, $urandom_range(1, 6), 1'b1);
    step(0, 479, 1'b0, 1'b0, 0, 1'b1);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        x = $urandom_range(0, 700);
        y = $urandom_range(0, 520);
      end else begin
        k = $urandom_range(0, 5);
        x = near_coord(cx[k]);
        y = near_coord(cy[k]);
      end
      step(x, y, ($urandom_range(0, 3) == 0), ($urandom_range(0, 40) == 0),
           $urandom_range(0, 7), ($urandom_range(0, 700) != 0));
    end
    step(0, 0, 1'b0, 1'b0, 0, 1'b1);
    @(negedge clk);
    pocketHit = 1'b0;
    startOfFrame = 1'b0;
    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: got no finish expected finish within 2ms");
    $fatal(1, "timeout");
  end

endmodule
